fault_collection_cam: RTL
=========================

// Module: fault_collection_cam
// PURPOSE
//  Upstream stage of spare_allocation_analyzer. Collects BIST fault addresses into a pivot CAM and a nonpivot CAM.
//  - Pivot: a fault sharing neither row nor column with any stored pivot.
//  - Nonpivot: a fault sharing a row or column with a stored pivot.
//  Exports both CAMs as flat buses. Flags the memory as unrepairable when a CAM overflows.
//  Asserts collect_done when BIST ends, which starts the analyzer.
// PARAMETERS
//  PCAM   8   pivot CAM entries (= row spares + col spares); max 32, since index field is 5b
//  NPCAM  16  nonpivot CAM entries
// PORTS
//  clk                  in   1          single clock, rising edge
//  rst                  in   1          synchronous, active-high
//  fault_valid          in   1          fault_row/fault_col valid
//  fault_ready          out  1          block can accept a fault
//  fault_row            in   10         faulty row address
//  fault_col            in   10         faulty column address
//  bist_done            in   1          BIST finished; no more faults
//  clear                in   1          empty both CAMs, return to IDLE
//  pivot_fault_addr     out  PCAM*26    entry i at [i*26+:26]
//  nonpivot_fault_addr  out  NPCAM*17   entry j at [j*17+:17]
//  pivot_cnt            out  6          valid pivot entries
//  nonpivot_cnt         out  6          valid nonpivot entries
//  collect_done         out  1          level; CAM contents final
//  unrepairable         out  1          sticky; CAM overflow
// BEHAVIOUR
//  Formats:
//  - Pivot: [25] valid, [24:15] row, [14:5] col, [4:0] linked-nonpivot count (saturates at 31).
//  - Nonpivot: [16] valid, [15] dir (0 = shares pivot row, 1 = shares pivot col), [14:5] unshared addr, [4:0] pivot index.
//  Reset or clear, same cycle either way, next edge:
//  - All entries 0, counts 0, collect_done=0, unrepairable=0, state IDLE.
//  - clear has priority over every other event.
//  FSM states: IDLE, CLASSIFY, DONE, FAIL.
//  - fault_ready=1 only in IDLE.
//  - IDLE: a fault is accepted when fault_valid & fault_ready. It latches into fault_q and the FSM goes to CLASSIFY.
//  - IDLE with bist_done=1 and no fault_valid: go to DONE.
//  - If bist_done and fault_valid are both high in IDLE, the fault is accepted. bist_done is remembered and DONE is entered after CLASSIFY.
//  - CLASSIFY (one cycle): parallel compare of fault_q against all valid entries. The CAM write lands at the end of this cycle. Then IDLE, or DONE if bist_done was seen, or FAIL on overflow.
//  - Throughput is one fault per 2 cycles. A fault is visible in the CAM outputs 2 edges after acceptance.
//  Classification priority:
//  1. Exact match with a pivot (row & col): discard, no change.
//  2. Exact match with a nonpivot: discard. The nonpivot's row/col is reconstructed from its pivot's row/col and dir.
//  3. Lowest-index pivot with equal row: nonpivot, dir=0, addr=col. Increment that pivot's count.
//  4. Else lowest-index pivot with equal col: nonpivot, dir=1, addr=row. Increment that pivot's count.
//  5. Else: new pivot at index pivot_cnt, count field 0.
//  - Entries fill lowest free index first. They are never removed except by clear/rst.
//  Overflow:
//  - A new pivot is needed with pivot_cnt==PCAM, or a nonpivot with nonpivot_cnt==NPCAM.
//  - No write occurs. unrepairable=1 and the FSM goes to FAIL.
//  - FAIL also sets collect_done=1.
//  DONE and FAIL hold until clear or rst. Faults offered there are not accepted (fault_ready=0).
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. Fault (5,7) then (9,3): pivot0={1,5,7,0}, pivot1={1,9,3,0}, pivot_cnt=2, nonpivot_cnt=0.
//  2. Pivot (5,7), then (5,20): np0={1,0,20,0} and pivot0 count=1. Then (12,7): np1={1,1,12,0} and count=2.
//  3. Repeat (5,7) and (5,20) after test 2: no entry or count change.
//  4. PCAM=8, nine faults with distinct rows/cols: 8 pivots stored, unrepairable=1 two edges after the 9th is accepted, fault_ready=0.
//  5. bist_done with fault_valid (3,3) in IDLE: (3,3) stored, then collect_done=1; next fault is not accepted.
//  6. rst (and separately clear) while in CLASSIFY: next edge all outputs 0, fault_ready=1; the latched fault is never written.

Source files
------------

// File: rtl/fault_collection_cam_if.sv
// Fault handshake between the BIST engine and the fault collection CAM.
// The BIST side drives address/valid, the CAM side answers with ready.
interface fault_collection_cam_if;
    logic       fault_valid;
    logic       fault_ready;
    logic [9:0] fault_row;
    logic [9:0] fault_col;

    modport master (
        output fault_valid,
        output fault_row,
        output fault_col,
        input  fault_ready
    );

    modport slave (
        input  fault_valid,
        input  fault_row,
        input  fault_col,
        output fault_ready
    );
endinterface

// File: rtl/fault_collection_cam.sv
// Sorts BIST fault addresses into a pivot CAM and a nonpivot CAM for the
// spare allocation analyzer; flags the memory unrepairable on CAM overflow.
module fault_collection_cam #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fault_collection_cam_if.slave   flt,
    input  logic                    i_bist_done,
    input  logic                    i_clear,
    output logic [PCAM*26-1:0]      o_pivot_fault_addr,
    output logic [NPCAM*17-1:0]     o_nonpivot_fault_addr,
    output logic [5:0]              o_pivot_cnt,
    output logic [5:0]              o_nonpivot_cnt,
    output logic                    o_collect_done,
    output logic                    o_unrepairable
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_DONE     = 2'd2,
        ST_FAIL     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        w_accept;

    logic [9:0]  r_fq_row;
    logic [9:0]  r_fq_col;
    logic        r_bist_seen;
    logic        r_collect_done;
    logic        r_unrepairable;
    logic [5:0]  r_pcnt;
    logic [5:0]  r_npcnt;

    logic        r_piv_valid [PCAM];
    logic [9:0]  r_piv_row   [PCAM];
    logic [9:0]  r_piv_col   [PCAM];
    logic [4:0]  r_piv_cnt   [PCAM];

    logic        r_np_valid  [NPCAM];
    logic        r_np_dir    [NPCAM];
    logic [9:0]  r_np_addr   [NPCAM];
    logic [4:0]  r_np_idx    [NPCAM];

    logic [9:0]  w_np_row    [NPCAM];
    logic [9:0]  w_np_col    [NPCAM];

    logic        w_piv_hit;
    logic        w_np_hit;
    logic        w_row_found;
    logic        w_col_found;
    logic [4:0]  w_row_idx;
    logic [4:0]  w_col_idx;
    logic        w_new_piv;
    logic        w_new_np;
    logic        w_np_dir;
    logic [9:0]  w_np_addr;
    logic [4:0]  w_link_idx;
    logic        w_overflow;
    logic        w_write;

    // Rebuild each nonpivot's full address from its linked pivot and direction.
    always_comb begin
        logic [9:0] v_row;
        logic [9:0] v_col;
        for (int j = 0; j < NPCAM; j++) begin
            v_row = 10'd0;
            v_col = 10'd0;
            for (int k = 0; k < PCAM; k++) begin
                if (r_np_idx[j] == 5'(k)) begin
                    v_row = r_piv_row[k];
                    v_col = r_piv_col[k];
                end else begin
                    v_row = v_row;
                    v_col = v_col;
                end
            end
            w_np_row[j] = r_np_dir[j] ? r_np_addr[j] : v_row;
            w_np_col[j] = r_np_dir[j] ? v_col : r_np_addr[j];
        end
    end

    // Parallel compare of the latched fault against every valid entry.
    always_comb begin
        w_piv_hit   = 1'b0;
        w_np_hit    = 1'b0;
        w_row_found = 1'b0;
        w_col_found = 1'b0;
        w_row_idx   = 5'd0;
        w_col_idx   = 5'd0;
        for (int i = 0; i < PCAM; i++) begin
            if (r_piv_valid[i]) begin
                if ((r_piv_row[i] == r_fq_row) && (r_piv_col[i] == r_fq_col)) begin
                    w_piv_hit = 1'b1;
                end else begin
                    w_piv_hit = w_piv_hit;
                end
                if ((r_piv_row[i] == r_fq_row) && !w_row_found) begin
                    w_row_found = 1'b1;
                    w_row_idx   = 5'(i);
                end else begin
                    w_row_found = w_row_found;
                end
                if ((r_piv_col[i] == r_fq_col) && !w_col_found) begin
                    w_col_found = 1'b1;
                    w_col_idx   = 5'(i);
                end else begin
                    w_col_found = w_col_found;
                end
            end else begin
                w_piv_hit = w_piv_hit;
            end
        end
        for (int j = 0; j < NPCAM; j++) begin
            if (r_np_valid[j] && (w_np_row[j] == r_fq_row) && (w_np_col[j] == r_fq_col)) begin
                w_np_hit = 1'b1;
            end else begin
                w_np_hit = w_np_hit;
            end
        end
        w_new_np   = !w_piv_hit && !w_np_hit && (w_row_found || w_col_found);
        w_new_piv  = !w_piv_hit && !w_np_hit && !w_row_found && !w_col_found;
        w_np_dir   = !w_row_found;
        w_np_addr  = w_row_found ? r_fq_col : r_fq_row;
        w_link_idx = w_row_found ? w_row_idx : w_col_idx;
        w_overflow = (r_state == ST_CLASSIFY) &&
                     ((w_new_piv && (r_pcnt == 6'(PCAM))) ||
                      (w_new_np && (r_npcnt == 6'(NPCAM))));
        w_write    = (r_state == ST_CLASSIFY) && !w_overflow;
    end

    // Next-state logic; the accept strobe is only possible while idle.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flt.fault_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_CLASSIFY;
                end else if (i_bist_done) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CLASSIFY: begin
                if (w_overflow) begin
                    w_state_nx = ST_FAIL;
                end else if (r_bist_seen) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DONE:  w_state_nx = ST_DONE;
            ST_FAIL:  w_state_nx = ST_FAIL;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Fault latch, remembered bist_done and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_fq_row       <= 10'd0;
            r_fq_col       <= 10'd0;
            r_bist_seen    <= 1'b0;
            r_collect_done <= 1'b0;
            r_unrepairable <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fq_row    <= flt.fault_row;
                r_fq_col    <= flt.fault_col;
                r_bist_seen <= i_bist_done;
            end
            if (w_overflow) begin
                r_unrepairable <= 1'b1;
            end
            if ((w_state_nx == ST_DONE) || (w_state_nx == ST_FAIL)) begin
                r_collect_done <= 1'b1;
            end
        end
    end

    // CAM writes land at the end of the classify cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pcnt  <= 6'd0;
            r_npcnt <= 6'd0;
            for (int i = 0; i < PCAM; i++) begin
                r_piv_valid[i] <= 1'b0;
                r_piv_row[i]   <= 10'd0;
                r_piv_col[i]   <= 10'd0;
                r_piv_cnt[i]   <= 5'd0;
            end
            for (int j = 0; j < NPCAM; j++) begin
                r_np_valid[j] <= 1'b0;
                r_np_dir[j]   <= 1'b0;
                r_np_addr[j]  <= 10'd0;
                r_np_idx[j]   <= 5'd0;
            end
        end else if (w_write) begin
            if (w_new_piv) begin
                r_pcnt <= r_pcnt + 6'd1;
            end
            if (w_new_np) begin
                r_npcnt <= r_npcnt + 6'd1;
            end
            for (int i = 0; i < PCAM; i++) begin
                if (w_new_piv && (r_pcnt == 6'(i))) begin
                    r_piv_valid[i] <= 1'b1;
                    r_piv_row[i]   <= r_fq_row;
                    r_piv_col[i]   <= r_fq_col;
                    r_piv_cnt[i]   <= 5'd0;
                end else if (w_new_np && (w_link_idx == 5'(i)) && (r_piv_cnt[i] != 5'd31)) begin
                    r_piv_cnt[i] <= r_piv_cnt[i] + 5'd1;
                end
            end
            for (int j = 0; j < NPCAM; j++) begin
                if (w_new_np && (r_npcnt == 6'(j))) begin
                    r_np_valid[j] <= 1'b1;
                    r_np_dir[j]   <= w_np_dir;
                    r_np_addr[j]  <= w_np_addr;
                    r_np_idx[j]   <= w_link_idx;
                end
            end
        end
    end

    for (genvar gi = 0; gi < PCAM; gi++) begin : g_piv_out
        assign o_pivot_fault_addr[gi*26 +: 26] =
            {r_piv_valid[gi], r_piv_row[gi], r_piv_col[gi], r_piv_cnt[gi]};
    end

    for (genvar gj = 0; gj < NPCAM; gj++) begin : g_np_out
        assign o_nonpivot_fault_addr[gj*17 +: 17] =
            {r_np_valid[gj], r_np_dir[gj], r_np_addr[gj], r_np_idx[gj]};
    end

    assign flt.fault_ready    = (r_state == ST_IDLE);
    assign o_pivot_cnt        = r_pcnt;
    assign o_nonpivot_cnt     = r_npcnt;
    assign o_collect_done     = r_collect_done;
    assign o_unrepairable     = r_unrepairable;

endmodule
